// File: rtl/hazard_ctrl.sv
// Purpose: hazard/forwarding controller for the 5-stage MIPS pipeline, with MDU busy tracking,
//          data-memory wait stalls and a saturating stall-cycle counter.
// Latency: forwarding, stall and flush outputs are combinational; md_busy and stall_cnt are registered.
// Backpressure: dmem_ready=0 with mem_req_m freezes F..M and bubbles W; other hazards hold F/D and bubble E.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   branch_d, rs_d, rt_d, hilo_use_d   D-stage instruction info
//   rs_e, rt_e, *_e                    E-stage sources, destination, load flag, MDU issue
//   reg_write_m/w, write_reg_m/w       M/W destinations; mem_to_reg_m marks a load in M
//   mem_req_m, dmem_ready              data-memory handshake
//   stall_*, flush_*                   pipeline-register hold and bubble controls
//   forward_*                          operand forwarding selects
//   md_busy, stall_cnt                 MDU occupancy, stalled-cycle count
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              mem_to_reg_e,
  input  logic              mem_to_reg_m,
  input  logic              mem_req_m,
  input  logic              dmem_ready,
  input  logic              md_start_e,
  input  logic              md_is_div_e,
  input  logic              hilo_use_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_e,
  output logic              flush_w,
  output logic              forward_ad,
  output logic              forward_bd,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MdCw   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam logic [MdCw-1:0] MulLoad = MdCw'(MUL_LAT - 1);
  localparam logic [MdCw-1:0] DivLoad = MdCw'(DIV_LAT - 1);

  typedef enum logic {IDLE, BUSY} mdStateT;

  mdStateT         mdState, mdStateNext;
  logic [MdCw-1:0] mdCnt, mdCntNext;

  logic lwStall, brStall, mdStall, memStall, anyHazard;

  // Register 0 is hardwired to zero, so a destination of r0 never creates a dependency.
  logic wrENz, wrMNz, wrWNz, rtENz;
  assign wrENz = (write_reg_e != '0);
  assign wrMNz = (write_reg_m != '0);
  assign wrWNz = (write_reg_w != '0);
  assign rtENz = (rt_e != '0);

  // Forwarding: the youngest producer (M) wins over W.
  always_comb begin
    forward_ae = 2'b00;
    forward_be = 2'b00;
    if (reg_write_m && wrMNz && (rs_e == write_reg_m))      forward_ae = 2'b10;
    else if (reg_write_w && wrWNz && (rs_e == write_reg_w)) forward_ae = 2'b01;
    if (reg_write_m && wrMNz && (rt_e == write_reg_m))      forward_be = 2'b10;
    else if (reg_write_w && wrWNz && (rt_e == write_reg_w)) forward_be = 2'b01;
  end

  assign forward_ad = reg_write_m && wrMNz && (rs_d == write_reg_m);
  assign forward_bd = reg_write_m && wrMNz && (rt_d == write_reg_m);

  assign lwStall = mem_to_reg_e && rtENz && ((rs_d == rt_e) || (rt_d == rt_e));

  // An ALU result sitting in M reaches D through forward_ad/bd; only a load in M must wait.
  assign brStall = branch_d &&
                   ((reg_write_e && wrENz && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                    (mem_to_reg_m && wrMNz && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));

  assign mdStall  = hilo_use_d && md_busy;
  assign memStall = mem_req_m && !dmem_ready;

  assign anyHazard = lwStall || brStall || mdStall;

  assign stall_f = anyHazard || memStall;
  assign stall_d = stall_f;
  assign stall_e = memStall;
  assign stall_m = memStall;
  assign flush_w = memStall;
  // While memory waits, E is frozen with its instruction intact; the bubble goes in once it releases.
  assign flush_e = anyHazard && !memStall;

  // MDU occupancy: load LAT-1 on accept, busy while counting down to 0 inclusive.
  always_comb begin
    mdStateNext = mdState;
    mdCntNext   = mdCnt;
    case (mdState)
      IDLE: begin
        if (md_start_e && !memStall) begin
          mdStateNext = BUSY;
          mdCntNext   = md_is_div_e ? DivLoad : MulLoad;
        end
      end
      BUSY: begin
        // The MDU runs independently of the pipeline, so memory stalls do not pause it.
        if (mdCnt == '0) mdStateNext = IDLE;
        else             mdCntNext   = mdCnt - MdCw'(1);
      end
      default: mdStateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdState <= IDLE;
      mdCnt   <= '0;
    end else begin
      mdState <= mdStateNext;
      mdCnt   <= mdCntNext;
    end
  end

  assign md_busy = (mdState == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_f && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk, rst_n;
  logic       branch_d;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       mem_to_reg_e, mem_to_reg_m, mem_req_m, dmem_ready;
  logic       md_start_e, md_is_div_e, hilo_use_d;

  logic        stall_f, stall_d, stall_e, stall_m, flush_e, flush_w;
  logic        forward_ad, forward_bd, md_busy;
  logic [1:0]  forward_ae, forward_be;
  logic [31:0] stall_cnt;

  logic        sStallF, sStallD, sStallE, sStallM, sFlushE, sFlushW;
  logic        sFad, sFbd, sBusy;
  logic [1:0]  sFae, sFbe;
  logic [3:0]  sStallCnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .branch_d(branch_d), .rs_d(rs_d), .rt_d(rt_d),
    .rs_e(rs_e), .rt_e(rt_e), .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w), .write_reg_e(write_reg_e), .write_reg_m(write_reg_m),
    .write_reg_w(write_reg_w), .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .mem_req_m(mem_req_m), .dmem_ready(dmem_ready), .md_start_e(md_start_e),
    .md_is_div_e(md_is_div_e), .hilo_use_d(hilo_use_d),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_e(flush_e), .flush_w(flush_w), .forward_ad(forward_ad), .forward_bd(forward_bd),
    .forward_ae(forward_ae), .forward_be(forward_be), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .branch_d(branch_d), .rs_d(rs_d), .rt_d(rt_d),
    .rs_e(rs_e), .rt_e(rt_e), .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w), .write_reg_e(write_reg_e), .write_reg_m(write_reg_m),
    .write_reg_w(write_reg_w), .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .mem_req_m(mem_req_m), .dmem_ready(dmem_ready), .md_start_e(md_start_e),
    .md_is_div_e(md_is_div_e), .hilo_use_d(hilo_use_d),
    .stall_f(sStallF), .stall_d(sStallD), .stall_e(sStallE), .stall_m(sStallM),
    .flush_e(sFlushE), .flush_w(sFlushW), .forward_ad(sFad), .forward_bd(sFbd),
    .forward_ae(sFae), .forward_be(sFbe), .md_busy(sBusy), .stall_cnt(sStallCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic       brD;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic       rwE;
    logic [4:0] wrE;
    logic       rwM;
    logic [4:0] wrM;
    logic       m2rM;
    logic       rwW;
    logic [4:0] wrW;
    logic       m2rE, memReq, dReady, hilo;
    logic       xStall, xStallE, xFlushE, xFad, xFbd;
    logic [1:0] xFae, xFbe;
  } vecT;

  vecT vecs[$];

  task automatic add(input logic brD, input logic [4:0] rsD, rtD, rsE, rtE,
                     input logic rwE, input logic [4:0] wrE,
                     input logic rwM, input logic [4:0] wrM, input logic m2rM,
                     input logic rwW, input logic [4:0] wrW,
                     input logic m2rE, memReq, dReady, hilo,
                     input logic xStall, xStallE, xFlushE, xFad, xFbd,
                     input logic [1:0] xFae, xFbe);
    vecT v;
    v.brD = brD; v.rsD = rsD; v.rtD = rtD; v.rsE = rsE; v.rtE = rtE;
    v.rwE = rwE; v.wrE = wrE; v.rwM = rwM; v.wrM = wrM; v.m2rM = m2rM;
    v.rwW = rwW; v.wrW = wrW; v.m2rE = m2rE; v.memReq = memReq;
    v.dReady = dReady; v.hilo = hilo;
    v.xStall = xStall; v.xStallE = xStallE; v.xFlushE = xFlushE;
    v.xFad = xFad; v.xFbd = xFbd; v.xFae = xFae; v.xFbe = xFbe;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    branch_d = 0; rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0; mem_req_m = 0; dmem_ready = 1;
    md_start_e = 0; md_is_div_e = 0; hilo_use_d = 0;
  endtask

  // Issue one MDU op and count the cycles md_busy and the D-stage stall stay up.
  task automatic mduRun(input logic isDiv, input int lat, input string tag);
    int busyCycles = 0;
    int stallCycles = 0;
    setIdle();
    md_start_e = 1; md_is_div_e = isDiv;
    step();
    md_start_e = 0; hilo_use_d = 1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (md_busy) busyCycles++;
      if (stall_d && stall_f && flush_e) stallCycles++;
      step();
    end
    chk({tag, " busy cycles"}, busyCycles, lat);
    chk({tag, " stall cycles"}, stallCycles, lat);
    chk({tag, " busy after"}, md_busy, 0);
    setIdle();
  endtask

  initial begin
    int base;

    // brD rsD rtD rsE rtE rwE wrE rwM wrM m2rM rwW wrW m2rE memReq dReady hilo | stall stallE flushE fad fbd fae fbe
    add(0, 0, 0, 8, 0, 0, 0, 1, 8, 0, 1, 8, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'b10, 2'b00);
    add(0, 0, 0, 8, 0, 0, 0, 0, 8, 0, 1, 8, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'b01, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00);
    add(0, 0, 0, 5, 3, 0, 0, 1, 5, 0, 1, 3, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'b10, 2'b01);
    add(0, 0, 7, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 2'b00, 2'b00);
    add(0, 7, 7, 7, 7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00);
    add(0, 9, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0,  1, 0, 1, 0, 0, 2'b00, 2'b00);
    add(0, 2, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0,  1, 0, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 4, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 2'b00, 2'b00);
    add(1, 4, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 2'b00, 2'b00);
    add(1, 4, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 1, 0, 2'b00, 2'b00);
    add(1, 0, 6, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 2'b00, 2'b00);
    add(0, 4, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 2'b00, 2'b00);
    add(0, 9, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00);

    setIdle();
    rst_n = 0;
    #12;
    chk("reset md_busy", md_busy, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset stall_f", stall_f, 0);
    step();
    rst_n = 1;
    step();

    foreach (vecs[i]) begin
      branch_d = vecs[i].brD; rs_d = vecs[i].rsD; rt_d = vecs[i].rtD;
      rs_e = vecs[i].rsE; rt_e = vecs[i].rtE;
      reg_write_e = vecs[i].rwE; write_reg_e = vecs[i].wrE;
      reg_write_m = vecs[i].rwM; write_reg_m = vecs[i].wrM; mem_to_reg_m = vecs[i].m2rM;
      reg_write_w = vecs[i].rwW; write_reg_w = vecs[i].wrW;
      mem_to_reg_e = vecs[i].m2rE; mem_req_m = vecs[i].memReq;
      dmem_ready = vecs[i].dReady; hilo_use_d = vecs[i].hilo;
      #1;
      chk($sformatf("vec%0d stall_f", i), stall_f, vecs[i].xStall);
      chk($sformatf("vec%0d stall_d", i), stall_d, vecs[i].xStall);
      chk($sformatf("vec%0d stall_e", i), stall_e, vecs[i].xStallE);
      chk($sformatf("vec%0d stall_m", i), stall_m, vecs[i].xStallE);
      chk($sformatf("vec%0d flush_w", i), flush_w, vecs[i].xStallE);
      chk($sformatf("vec%0d flush_e", i), flush_e, vecs[i].xFlushE);
      chk($sformatf("vec%0d forward_ad", i), forward_ad, vecs[i].xFad);
      chk($sformatf("vec%0d forward_bd", i), forward_bd, vecs[i].xFbd);
      chk($sformatf("vec%0d forward_ae", i), forward_ae, vecs[i].xFae);
      chk($sformatf("vec%0d forward_be", i), forward_be, vecs[i].xFbe);
      step();
    end

    mduRun(1'b1, 32, "div");
    mduRun(1'b0, 4, "mul");

    // Pending load-use while memory waits: E held for 3 cycles, then one bubble.
    setIdle();
    mem_to_reg_e = 1; rt_e = 9; rs_d = 9;
    mem_req_m = 1; dmem_ready = 0;
    #1;
    base = stall_cnt;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("memwait%0d stall_e", c), stall_e && stall_m && flush_w, 1);
      chk($sformatf("memwait%0d flush_e", c), flush_e, 0);
      chk($sformatf("memwait%0d stall_f", c), stall_f, 1);
      step();
    end
    dmem_ready = 1;
    #1;
    chk("memdone flush_e", flush_e, 1);
    chk("memdone stall_e", stall_e, 0);
    step();
    setIdle();
    #1;
    chk("memwait stall_cnt delta", stall_cnt - base, 4);
    chk("memwait stall_f after", stall_f, 0);

    // MDU issue blocked by a memory stall is dropped.
    setIdle();
    mem_req_m = 1; dmem_ready = 0; md_start_e = 1; md_is_div_e = 1;
    step();
    setIdle();
    #1;
    chk("start during memstall ignored", md_busy, 0);

    // Reset in the middle of a divide.
    md_start_e = 1; md_is_div_e = 1;
    step();
    md_start_e = 0;
    repeat (9) step();
    chk("div cycle10 busy", md_busy, 1);
    hilo_use_d = 1;
    rst_n = 0;
    #1;
    chk("midreset md_busy", md_busy, 0);
    chk("midreset stall_cnt", stall_cnt, 0);
    chk("midreset small stall_cnt", sStallCnt, 0);
    chk("midreset stall_f", stall_f, 0);
    step();
    rst_n = 1;
    step();
    chk("post reset md_busy", md_busy, 0);
    chk("post reset stall_f", stall_f, 0);

    // 20 stalled cycles: the 4-bit counter pins at 15.
    setIdle();
    mem_req_m = 1; dmem_ready = 0;
    repeat (20) step();
    setIdle();
    #1;
    chk("saturating stall_cnt", sStallCnt, 15);
    chk("wide stall_cnt", stall_cnt, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
